// File: rtl/pt_write_buffer_if.sv
// Memory-side write port of pt_write_buffer: request/grant handshake carrying
// one 36-bit two-pixel word with per-half write enables.
interface pt_write_buffer_if;
  logic        mem_wr;
  logic [18:0] mem_addr;
  logic [35:0] mem_data;
  logic [1:0]  mem_we_mask;
  logic        mem_grant;

  modport master (output mem_wr, mem_addr, mem_data, mem_we_mask, input mem_grant);
  modport slave  (input mem_wr, mem_addr, mem_data, mem_we_mask, output mem_grant);
endinterface

// File: rtl/pt_write_buffer.sv
// Projective-transform write buffer: (x,y) -> linear address, FIFO queueing and
// request/grant drain to a two-pixel-per-word memory. Optional macro PT_WB_MERGE_EN.
module pt_write_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [17:0]              pt_pixel_write,
  input  logic [9:0]               pt_x,
  input  logic [8:0]               pt_y,
  input  logic                     pt_wr,
  input  logic                     frame_flag,
  output logic                     ptflag,
  pt_write_buffer_if.master        mem,
  output logic                     write_bank,
  output logic [15:0]              drop_count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2+1:0] FLAG_LVL = (DEPTH_LOG2+2)'(DEPTH - 3);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [10:0]           X_LIM    = 11'(H_RES);
  localparam logic [9:0]            Y_LIM    = 10'(V_RES);

  typedef struct packed {
    logic        bank;
    logic [18:0] lin;
    logic [17:0] pix;
  } entry_t;

  entry_t                  fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]     count, count_next;
  entry_t                  s1;
  logic                    s1_valid;

  logic                    in_range, accept, full, push, pop, ovf, merge;
  logic [1:0]              pop_cnt, drop_inc;
  logic [16:0]             drop_sum;
  logic [18:0]             lin_calc;
  logic [DEPTH_LOG2+1:0]   occ_next;
  entry_t                  head;
  logic                    wr_valid;
  logic [18:0]             wr_addr;
  logic [35:0]             wr_data;
  logic [1:0]              wr_mask;

  assign in_range = ({1'b0, pt_x} < X_LIM) && ({1'b0, pt_y} < Y_LIM);
  assign accept   = pt_wr && in_range;
  assign lin_calc = 19'(pt_y) * 19'(H_RES) + 19'(pt_x);

  assign head     = fifo_mem[rd_ptr];
  assign wr_valid = (count != '0);
  assign full     = (count == FULL_LVL);
  assign pop      = wr_valid && mem.mem_grant;

`ifdef PT_WB_MERGE_EN
  entry_t second;
  assign second = fifo_mem[rd_ptr + PTR_ONE];
  // Only pairs already resident are merged; the head never waits for a partner.
  assign merge  = (count > 1) && (head.bank == second.bank) &&
                  (head.lin[18:1] == second.lin[18:1]) && (head.lin[0] != second.lin[0]);
`else
  assign merge  = 1'b0;
`endif

  assign pop_cnt    = pop ? (merge ? 2'd2 : 2'd1) : 2'd0;
  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign push       = s1_valid && (!full || pop);
  assign ovf        = s1_valid && !push;
  assign count_next = count - (DEPTH_LOG2+1)'(pop_cnt) + (DEPTH_LOG2+1)'(push);
  assign occ_next   = {1'b0, count_next} + (DEPTH_LOG2+2)'(accept);

  assign drop_inc = {1'b0, pt_wr && !in_range} + {1'b0, ovf};
  assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    if (wr_valid) begin
      wr_addr = {head.bank, head.lin[18:1]};
      if (head.lin[0]) begin
        wr_data[35:18] = head.pix;
        wr_mask        = 2'b10;
      end else begin
        wr_data[17:0]  = head.pix;
        wr_mask        = 2'b01;
      end
`ifdef PT_WB_MERGE_EN
      if (merge) begin
        wr_data = head.lin[0] ? {head.pix, second.pix} : {second.pix, head.pix};
        wr_mask = 2'b11;
      end
`endif
    end
  end

  assign mem.mem_wr      = wr_valid;
  assign mem.mem_addr    = wr_addr;
  assign mem.mem_data    = wr_data;
  assign mem.mem_we_mask = wr_mask;

  // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ptflag     <= 1'b0;
      write_bank <= 1'b0;
      drop_count <= '0;
    end else begin
      s1_valid <= accept;
      if (pt_wr) s1 <= '{bank: write_bank, lin: lin_calc, pix: pt_pixel_write};
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr     <= rd_ptr + DEPTH_LOG2'(pop_cnt);
      count      <= count_next;
      ptflag     <= (occ_next <= FLAG_LVL);
      write_bank <= write_bank ^ frame_flag;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // NOTE: storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s1;
  end

endmodule
